// File: rtl/cache_miss_engine.sv
// Line-transfer engine for a cache miss: optional dirty-victim write-back burst, then a line fill.
// Optional build macro CRITICAL_BEAT_FIRST_EN: fill starts at the missing beat and wraps.
module cache_miss_engine #(
  parameter  int ADDR_SIZE      = 32,
  parameter  int DATA_SIZE      = 32,
  parameter  int BLOCK_SIZE     = 6,
  parameter  int INDEX_SIZE     = 7,
  parameter  int WR_M_DATA_SIZE = 4,
  parameter  int TAG_SIZE       = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE,
  localparam int BEATS          = (1 << BLOCK_SIZE) / (WR_M_DATA_SIZE * DATA_SIZE / 8),
  localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                miss_valid,
  output logic                                miss_ready,
  input  logic [ADDR_SIZE-1:0]                miss_addr,
  input  logic                                miss_dirty,
  input  logic [TAG_SIZE-1:0]                 victim_tag,
  output logic                                busy,
  output logic                                fill_done,
  output logic                                arr_rd_en,
  output logic [BEAT_W-1:0]                   arr_rd_beat,
  input  logic [WR_M_DATA_SIZE*DATA_SIZE-1:0] arr_rd_data,
  output logic                                arr_wr_en,
  output logic [BEAT_W-1:0]                   arr_wr_beat,
  output logic [WR_M_DATA_SIZE*DATA_SIZE-1:0] arr_wr_data,
  output logic                                addr_valid_out,
  input  logic                                addr_ready,
  output logic [ADDR_SIZE-1:0]                addr_out_m,
  output logic                                rw_out,
  output logic                                valid_wb,
  input  logic                                ready_wb,
  output logic [WR_M_DATA_SIZE*DATA_SIZE-1:0] data_out_m,
  input  logic                                valid_ld,
  input  logic [WR_M_DATA_SIZE*DATA_SIZE-1:0] data_in_m,
  output logic                                ready_ld
);

  localparam int LINE_W      = WR_M_DATA_SIZE * DATA_SIZE;
  localparam int LINE_ADDR_W = ADDR_SIZE - BLOCK_SIZE;
  localparam int BEAT_LSB    = BLOCK_SIZE - $clog2(BEATS);

  generate
    if (BEATS < 1 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
      $error("cache_miss_engine: beats per line must be a power of two and at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, WB_ADDR, WB_RD, WB_DATA, LD_ADDR, LD_DATA, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      wb_cnt_q, wb_cnt_d;
  logic [BEAT_W-1:0]      ld_cnt_q, ld_cnt_d;
  logic                   rd_wait_q, rd_wait_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic [BEAT_W-1:0]      start_beat_q, start_beat_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]      data_out_q, data_out_d;

  logic [BEAT_W-1:0]      start_beat_in;
  logic [ADDR_SIZE-1:0]   wb_addr;
  logic                   unused_offset;

`ifdef CRITICAL_BEAT_FIRST_EN
  assign start_beat_in = (BEATS > 1) ? miss_addr[BEAT_LSB +: BEAT_W] : '0;
`else
  assign start_beat_in = '0;
`endif

  // Byte offset below the beat field never reaches memory: bursts are beat-aligned.
  assign unused_offset = ^miss_addr[BLOCK_SIZE-1:0];

  assign wb_addr = {victim_tag, miss_addr[BLOCK_SIZE +: INDEX_SIZE], {BLOCK_SIZE{1'b0}}};

  function automatic logic [ADDR_SIZE-1:0] load_addr(input logic [LINE_ADDR_W-1:0] line,
                                                      input logic [BEAT_W-1:0]      sb);
    logic [ADDR_SIZE-1:0] a;
    a = {line, {BLOCK_SIZE{1'b0}}};
    if (BEATS > 1) a = a | (ADDR_SIZE'(sb) << BEAT_LSB);
    return a;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    wb_cnt_d     = wb_cnt_q;
    ld_cnt_d     = ld_cnt_q;
    rd_wait_d    = rd_wait_q;
    line_d       = line_q;
    start_beat_d = start_beat_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;

    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          line_d       = miss_addr[ADDR_SIZE-1:BLOCK_SIZE];
          start_beat_d = start_beat_in;
          if (miss_dirty) begin
            state_d = WB_ADDR;
            addr_d  = wb_addr;
          end else begin
            state_d = LD_ADDR;
            addr_d  = load_addr(miss_addr[ADDR_SIZE-1:BLOCK_SIZE], start_beat_in);
          end
        end
      end
      WB_ADDR: begin
        if (addr_ready) begin
          state_d   = WB_RD;
          wb_cnt_d  = '0;
          rd_wait_d = 1'b0;
        end
      end
      WB_RD: begin
        // First cycle issues the array read, second cycle captures the returned beat.
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d  = 1'b0;
          data_out_d = arr_rd_data;
          state_d    = WB_DATA;
        end
      end
      WB_DATA: begin
        if (ready_wb) begin
          if (wb_cnt_q == BEAT_W'(BEATS - 1)) begin
            state_d = LD_ADDR;
            addr_d  = load_addr(line_q, start_beat_q);
          end else begin
            wb_cnt_d = wb_cnt_q + BEAT_W'(1);
            state_d  = WB_RD;
          end
        end
      end
      LD_ADDR: begin
        if (addr_ready) begin
          state_d  = LD_DATA;
          ld_cnt_d = '0;
        end
      end
      LD_DATA: begin
        if (valid_ld) begin
          if (ld_cnt_q == BEAT_W'(BEATS - 1)) state_d = DONE;
          else                                ld_cnt_d = ld_cnt_q + BEAT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wb_cnt_q     <= '0;
      ld_cnt_q     <= '0;
      rd_wait_q    <= 1'b0;
      line_q       <= '0;
      start_beat_q <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      wb_cnt_q     <= wb_cnt_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_wait_q    <= rd_wait_d;
      line_q       <= line_d;
      start_beat_q <= start_beat_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
    end
  end

  assign miss_ready     = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign fill_done      = (state_q == DONE);
  assign addr_valid_out = (state_q == WB_ADDR) || (state_q == LD_ADDR);
  assign rw_out         = (state_q == WB_ADDR);
  assign addr_out_m     = addr_q;
  assign valid_wb       = (state_q == WB_DATA);
  assign data_out_m     = data_out_q;
  assign arr_rd_en      = (state_q == WB_RD) && !rd_wait_q;
  assign arr_rd_beat    = wb_cnt_q;
  assign ready_ld       = (state_q == LD_DATA);
  assign arr_wr_en      = valid_ld && ready_ld;
  assign arr_wr_beat    = start_beat_q + ld_cnt_q;
  assign arr_wr_data    = data_in_m;

endmodule

// File: tb/tb_cache_miss_engine.sv
// Directed bench for cache_miss_engine at default parameters (4 beats of 128 bits per 64-byte line).
module tb_cache_miss_engine;

  localparam int AW = 32;
  localparam int TW = 19;
  localparam int BW = 2;
  localparam int LW = 128;

`ifdef CRITICAL_BEAT_FIRST_EN
  localparam bit CBF = 1'b1;
`else
  localparam bit CBF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_valid, miss_ready, miss_dirty, busy, fill_done;
  logic [AW-1:0] miss_addr, addr_out_m;
  logic [TW-1:0] victim_tag;
  logic          arr_rd_en, arr_wr_en, addr_valid_out, addr_ready, rw_out;
  logic [BW-1:0] arr_rd_beat, arr_wr_beat;
  logic [LW-1:0] arr_rd_data, arr_wr_data, data_out_m, data_in_m;
  logic          valid_wb, ready_wb, valid_ld, ready_ld;

  always #5 clk = ~clk;

  cache_miss_engine dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .victim_tag(victim_tag), .busy(busy), .fill_done(fill_done),
    .arr_rd_en(arr_rd_en), .arr_rd_beat(arr_rd_beat), .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_beat(arr_wr_beat), .arr_wr_data(arr_wr_data),
    .addr_valid_out(addr_valid_out), .addr_ready(addr_ready), .addr_out_m(addr_out_m),
    .rw_out(rw_out), .valid_wb(valid_wb), .ready_wb(ready_wb), .data_out_m(data_out_m),
    .valid_ld(valid_ld), .data_in_m(data_in_m), .ready_ld(ready_ld)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data array model: reads return one cycle after the strobe.
  logic [LW-1:0] arr [4];
  logic [LW-1:0] exp_arr [4];
  always @(posedge clk) begin
    if (arr_rd_en) arr_rd_data <= arr[arr_rd_beat];
    if (arr_wr_en) arr[arr_wr_beat] <= arr_wr_data;
  end

  int          overlap_cnt = 0;
  int unsigned rd_log[$];
  int unsigned wr_log[$];
  always @(negedge clk) begin
    if (valid_wb && addr_valid_out) overlap_cnt++;
    if (arr_rd_en) rd_log.push_back(int'(arr_rd_beat));
    if (arr_wr_en) wr_log.push_back(int'(arr_wr_beat));
  end

  function automatic logic [LW-1:0] pat(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base + 32'(k);
    return {4{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string tag, input bit want_wb);
    int n = 0;
    while (((want_wb ? valid_wb : addr_valid_out) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic issue(input string tag, input logic [AW-1:0] a, input logic d, input logic [TW-1:0] vt);
    miss_valid = 1'b1; miss_addr = a; miss_dirty = d; victim_tag = vt;
    tick();
    miss_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_miss_ready"}, miss_ready, 0);
  endtask

  task automatic addr_phase(input string tag, input logic [AW-1:0] exp_addr, input logic exp_rw);
    wait_sig(tag, 1'b0);
    check({tag, "_addr"}, addr_out_m, exp_addr);
    check({tag, "_rw"}, rw_out, exp_rw);
    repeat (2) tick();
    check({tag, "_addr_hold"}, {addr_valid_out, addr_out_m}, {1'b1, exp_addr});
    addr_ready = 1'b1;
    tick();
    addr_ready = 1'b0;
  endtask

  task automatic wb_phase(input int stall_beat);
    int rd_base = rd_log.size();
    int held_err = 0;
    logic [LW-1:0] held;
    for (int b = 0; b < 4; b++) begin
      wait_sig("wb", 1'b1);
      held = data_out_m;
      check($sformatf("wb_data%0d", b), data_out_m, exp_arr[b]);
      if (b == stall_beat) begin
        valid_ld = 1'b1;
        #1;
        check("wb_ready_ld", ready_ld, 0);
        check("wb_arr_wr_en", arr_wr_en, 0);
        valid_ld = 1'b0;
        repeat (5) begin
          tick();
          if (data_out_m !== held || valid_wb !== 1'b1) held_err++;
        end
        check("wb_stall_hold", held_err, 0);
      end
      ready_wb = 1'b1;
      tick();
      ready_wb = 1'b0;
    end
    check("wb_rd_pulses", rd_log.size() - rd_base, 4);
    if (rd_log.size() >= rd_base + 4)
      for (int b = 0; b < 4; b++) check($sformatf("wb_rd_beat%0d", b), rd_log[rd_base + b], b);
  endtask

  task automatic ld_phase(input string tag, input logic [AW-1:0] exp_addr, input int sb,
                          input logic [31:0] base);
    int wr_base;
    addr_phase(tag, exp_addr, 1'b0);
    wr_base = wr_log.size();
    for (int k = 0; k < 4; k++) begin
      valid_ld  = 1'b1;
      data_in_m = pat(base, k);
      exp_arr[(sb + k) % 4] = pat(base, k);
      tick();
      if (k == 1) begin
        valid_ld = 1'b0;
        tick();
      end
    end
    valid_ld = 1'b0;
    check({tag, "_fill_done"}, fill_done, 1);
    tick();
    check({tag, "_fill_done_end"}, {fill_done, busy, miss_ready}, 3'b001);
    check({tag, "_wr_count"}, wr_log.size() - wr_base, 4);
    if (wr_log.size() >= wr_base + 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_wr_beat%0d", tag, k), wr_log[wr_base + k], (sb + k) % 4);
    for (int b = 0; b < 4; b++) check($sformatf("%s_arr%0d", tag, b), arr[b], exp_arr[b]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    miss_valid = 1'b0; miss_addr = '0; miss_dirty = 1'b0; victim_tag = '0;
    addr_ready = 1'b0; ready_wb = 1'b0; valid_ld = 1'b0; data_in_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {busy, fill_done, addr_valid_out, rw_out, valid_wb, ready_ld, arr_rd_en, arr_wr_en},
          8'h00);
    check("rst_addr_out", addr_out_m, 0);
    check("rst_data_out", data_out_m, 0);
    rst_n = 1'b1;
    tick();
    check("rst_miss_ready", miss_ready, 1);

    valid_ld = 1'b1;
    #1;
    check("idle_ready_ld", ready_ld, 0);
    check("idle_arr_wr_en", arr_wr_en, 0);
    valid_ld = 1'b0;
    tick();

    issue("clean", 32'h0000_1234, 1'b0, '0);
    ld_phase("clean", CBF ? 32'h0000_1230 : 32'h0000_1200, CBF ? 3 : 0, 32'h1111_0000);

    issue("dirty", 32'h0000_1234, 1'b1, 19'h5A5A5);
    addr_phase("wb", 32'hB4B4_B200, 1'b1);
    wb_phase(2);
    ld_phase("dirty_ld", CBF ? 32'h0000_1230 : 32'h0000_1200, CBF ? 3 : 0, 32'h2222_0000);

    issue("abort", 32'h0000_3000, 1'b0, '0);
    addr_phase("abort", 32'h0000_3000, 1'b0);
    valid_ld  = 1'b1;
    data_in_m = pat(32'h3333_0000, 0);
    tick();
    data_in_m = pat(32'h3333_0000, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs",
          {busy, fill_done, addr_valid_out, rw_out, valid_wb, ready_ld, arr_rd_en, arr_wr_en},
          8'h00);
    check("abort_addr_out", addr_out_m, 0);
    check("abort_data_out", data_out_m, 0);
    valid_ld = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_release", {miss_ready, busy}, 2'b10);

    issue("crit", 32'h0000_1228, 1'b0, '0);
    ld_phase("crit", CBF ? 32'h0000_1220 : 32'h0000_1200, CBF ? 2 : 0, 32'h4444_0000);

    check("no_wb_addr_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_miss_engine.md
Name: cache_miss_engine

Overview:
Parametrised line-transfer engine that owns the memory side of a cache miss. It sits between the cache controller and data array on one side and the memory write-back/load channels on the other. On a miss it writes back a dirty victim line as a multi-beat burst, then fills the new line in beats, writing each beat straight into the data array. It generalises fixed 1-beat line transfers to BEATS beats with full valid/ready handshakes, plus an optional critical-beat-first fill.

Parameters:
ADDR_SIZE, 32, address width
DATA_SIZE, 32, word width in bits
BLOCK_SIZE, 6, log2 line size in bytes
INDEX_SIZE, 7, set index width
WR_M_DATA_SIZE, 4, words per memory beat
TAG_SIZE, ADDR_SIZE-BLOCK_SIZE-INDEX_SIZE, tag width
BEATS (local), (1<<BLOCK_SIZE)/(WR_M_DATA_SIZE*DATA_SIZE/8), beats per line; must be a power of two and >=1 (elaboration error otherwise)
BEAT_W (local), max($clog2(BEATS),1), beat index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  miss request
miss_ready  out  1  engine accepts request
miss_addr  in  ADDR_SIZE  missing address
miss_dirty  in  1  victim line dirty
victim_tag  in  TAG_SIZE  victim tag
busy  out  1  engine not idle
fill_done  out  1  one-cycle pulse when the line is installed
arr_rd_en  out  1  data-array read strobe
arr_rd_beat  out  BEAT_W  beat to read
arr_rd_data  in  WR_M_DATA_SIZE*DATA_SIZE  array read data, valid one cycle after arr_rd_en
arr_wr_en  out  1  data-array write strobe
arr_wr_beat  out  BEAT_W  beat to write
arr_wr_data  out  WR_M_DATA_SIZE*DATA_SIZE  fill data
addr_valid_out  out  1  memory address valid
addr_ready  in  1  memory accepts address
addr_out_m  out  ADDR_SIZE  line-aligned burst address
rw_out  out  1  1 = write-back, 0 = load
valid_wb  out  1  write-back beat valid
ready_wb  in  1  memory accepts write-back beat
data_out_m  out  WR_M_DATA_SIZE*DATA_SIZE  write-back beat
valid_ld  in  1  load beat valid
data_in_m  in  WR_M_DATA_SIZE*DATA_SIZE  load beat
ready_ld  out  1  engine accepts load beat

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. Reset forces IDLE and clears every registered output to 0: busy, fill_done, addr_valid_out, rw_out, valid_wb, data_out_m, addr_out_m, beat counters. miss_ready is 1 after reset.
- States: IDLE, WB_ADDR, WB_RD, WB_DATA, LD_ADDR, LD_DATA, DONE.
- IDLE: miss_ready=1, busy=0. When miss_valid is high, latch miss_addr, miss_dirty and victim_tag. Go to WB_ADDR if dirty, else LD_ADDR.
- In every non-IDLE state: miss_ready=0, busy=1. miss_valid is ignored.
- WB_ADDR: addr_valid_out=1, rw_out=1, addr_out_m={victim_tag, index, BLOCK_SIZE zeros}. These are held stable until addr_ready, then go to WB_RD with wb_cnt=0.
- WB_RD: arr_rd_en=1 for one cycle, arr_rd_beat=wb_cnt. Next cycle, capture arr_rd_data into data_out_m and go to WB_DATA.
- WB_DATA: valid_wb=1. data_out_m is held until ready_wb. On the handshake: if wb_cnt==BEATS-1, go to LD_ADDR; else increment wb_cnt and go to WB_RD.
- LD_ADDR: addr_valid_out=1, rw_out=0, addr_out_m={miss tag, index, zeros} (see optional feature). On addr_ready, go to LD_DATA with ld_cnt=0.
- LD_DATA: ready_ld=1. arr_wr_en = valid_ld & ready_ld, combinational. arr_wr_data=data_in_m. arr_wr_beat = (start_beat + ld_cnt) mod BEATS, wrapping. On each handshake increment ld_cnt. The last beat goes to DONE.
- DONE: fill_done=1 for exactly one cycle, then IDLE. A new miss is accepted no earlier than the cycle after DONE.
- Outside LD_DATA, ready_ld=0, so load beats are not consumed. valid_wb and addr_valid_out are never high together.
- Back-pressure of any length on addr_ready, ready_wb or valid_ld stalls the FSM with no lost or duplicated beat.
- rst_n asserted mid-burst aborts immediately. Partial array writes are not rolled back. After release the engine is in IDLE.
- BEATS==1: counters are constant 0. The FSM still passes through every state.

Optional Feature:
Macro CRITICAL_BEAT_FIRST_EN.
- Defined: start_beat = miss_addr beat field. The load address low bits select that beat, so memory returns the critical beat first and wraps. arr_wr_beat follows the wrap.
- Undefined: start_beat=0, the load address is line-aligned, and beats are written 0..BEATS-1.
- Write-back order is always 0..BEATS-1.

Test Plan:
- Clean miss, defaults (BEATS=4), miss_addr=0x0000_1234: one LD address 0x0000_1200 with rw_out=0; 4 load beats give arr_wr_beat 0,1,2,3; fill_done pulses one cycle after the 4th beat.
- Dirty miss, victim_tag=0x5A5A5, index from 0x1234: WB address {0x5A5A5,0x48,0} with rw_out=1; 4 write-back beats equal array beats 0..3; then the load burst; no valid_wb/addr_valid_out overlap.
- Back-pressure: ready_wb low 5 cycles on beat 2: data_out_m held constant, no extra arr_rd_en, beat 3 follows.
- Reset asserted during LD_DATA beat 1: all outputs 0 asynchronously; miss_ready=1 after release; a new miss completes normally.
- CRITICAL_BEAT_FIRST_EN defined, miss_addr=0x0000_1228: load address 0x0000_1220, arr_wr_beat order 2,3,0,1.
- valid_ld pulsed in IDLE and WB_DATA: ready_ld=0, arr_wr_en stays 0.
